// File: rtl/analyzer_sequencer.sv
// Runs one latched number through a bank of analyzer units in index order,
// handshaking each with go/done and collecting one result bit per unit.
module analyzer_sequencer #(
  parameter int unsigned N_UNITS = 4,
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   number_i,
  input  logic [N_UNITS-1:0] enable_mask_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [N_UNITS-1:0] flags_o,
  output logic [N_UNITS-1:0] timeout_o,
  output logic [WIDTH-1:0]   unit_number_o,
  output logic [N_UNITS-1:0] unit_go_o,
  input  logic [N_UNITS-1:0] unit_done_i,
  input  logic [N_UNITS-1:0] unit_result_i
);

  localparam int unsigned IDX_W = $clog2(N_UNITS + 1);
  localparam int unsigned TMR_W = 16;

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_END  = IDX_W'(N_UNITS);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SELECT  = 3'd1;
  localparam logic [2:0] ST_WAIT    = 3'd2;
  localparam logic [2:0] ST_RELEASE = 3'd3;
  localparam logic [2:0] ST_FINISH  = 3'd4;

  logic [2:0]         state_q,   state_d;
  logic [IDX_W-1:0]   idx_q,     idx_d;
  logic [TMR_W-1:0]   timer_q,   timer_d;
  logic [N_UNITS-1:0] mask_q,    mask_d;
  logic [WIDTH-1:0]   number_q,  number_d;
  logic [N_UNITS-1:0] flags_q,   flags_d;
  logic [N_UNITS-1:0] timeout_q, timeout_d;
  logic [N_UNITS-1:0] go_q,      go_d;
  logic               busy_q,    busy_d;
  logic               done_q,    done_d;

  // One-hot select of the current unit; all-zero once idx reaches N_UNITS
  logic [N_UNITS-1:0] sel_oh_c;
  logic               cur_en_c;
  logic               cur_done_c;
  logic               cur_result_c;

  assign sel_oh_c     = N_UNITS'(1) << idx_q;
  assign cur_en_c     = |(mask_q & sel_oh_c);
  assign cur_done_c   = |(unit_done_i & sel_oh_c);
  assign cur_result_c = |(unit_result_i & sel_oh_c);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    timer_d   = timer_q;
    mask_d    = mask_q;
    number_d  = number_q;
    flags_d   = flags_q;
    timeout_d = timeout_q;
    go_d      = '0;
    busy_d    = busy_q;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (start_i) begin
          number_d  = number_i;
          mask_d    = enable_mask_i;
          flags_d   = '0;
          timeout_d = '0;
          idx_d     = '0;
          busy_d    = 1'b1;
          state_d   = ST_SELECT;
        end
      end

      ST_SELECT: begin
        if (idx_q == IDX_END) begin
          done_d  = 1'b1;
          state_d = ST_FINISH;
        end else if (!cur_en_c) begin
          idx_d = idx_q + IDX_W'(1);
        end else begin
          timer_d = '0;
          go_d    = sel_oh_c;
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (cur_done_c) begin
          if (cur_result_c) begin
            flags_d = flags_q | sel_oh_c;
          end
          timer_d = '0;
          state_d = ST_RELEASE;
        end else if (timer_q == TMR_LAST) begin
          timeout_d = timeout_q | sel_oh_c;
          timer_d   = '0;
          state_d   = ST_RELEASE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
          go_d    = sel_oh_c;
        end
      end

      // Go is low here; wait for the unit to fall back to its initial state
      ST_RELEASE: begin
        if (!cur_done_c || (timer_q == TMR_LAST)) begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = ST_SELECT;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end

      ST_FINISH: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q     <= '0;
      timer_q   <= '0;
      mask_q    <= '0;
      number_q  <= '0;
      flags_q   <= '0;
      timeout_q <= '0;
      go_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      idx_q     <= idx_d;
      timer_q   <= timer_d;
      mask_q    <= mask_d;
      number_q  <= number_d;
      flags_q   <= flags_d;
      timeout_q <= timeout_d;
      go_q      <= go_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign flags_o       = flags_q;
  assign timeout_o     = timeout_q;
  assign unit_number_o = number_q;
  assign unit_go_o     = go_q;

endmodule

// File: tb/tb_analyzer_sequencer.sv
// Directed bench for analyzer_sequencer with simple behavioural unit models.
module tb_analyzer_sequencer;

  localparam int unsigned N = 4;
  localparam int unsigned W = 32;
  localparam int unsigned TO = 8;

  logic          clk;
  logic          reset;
  logic          start_i;
  logic [W-1:0]  number_i;
  logic [N-1:0]  enable_mask_i;
  logic          busy_o;
  logic          done_o;
  logic [N-1:0]  flags_o;
  logic [N-1:0]  timeout_o;
  logic [W-1:0]  unit_number_o;
  logic [N-1:0]  unit_go_o;
  logic [N-1:0]  unit_done_i;
  logic [N-1:0]  unit_result_i;

  analyzer_sequencer #(.N_UNITS(N), .WIDTH(W), .TIMEOUT(TO)) dut (
    .clk           (clk),
    .reset         (reset),
    .start_i       (start_i),
    .number_i      (number_i),
    .enable_mask_i (enable_mask_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .flags_o       (flags_o),
    .timeout_o     (timeout_o),
    .unit_number_o (unit_number_o),
    .unit_go_o     (unit_go_o),
    .unit_done_i   (unit_done_i),
    .unit_result_i (unit_result_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Unit model: done rises after dly go-high cycles, falls after rel go-low cycles
  int           dly [N];
  int           rel [N];
  logic [N-1:0] never_m;
  logic [N-1:0] res_m;
  logic [N-1:0] dn;
  int           gocnt [N];
  int           relcnt [N];

  always @(posedge clk) begin
    for (int u = 0; u < int'(N); u++) begin
      if (reset) begin
        dn[u]     <= 1'b0;
        gocnt[u]  <= 0;
        relcnt[u] <= 0;
      end else if (unit_go_o[u]) begin
        gocnt[u]  <= gocnt[u] + 1;
        relcnt[u] <= 0;
        if (!never_m[u] && (gocnt[u] + 1 >= dly[u])) dn[u] <= 1'b1;
      end else if (dn[u]) begin
        relcnt[u] <= relcnt[u] + 1;
        if (relcnt[u] + 1 >= rel[u]) dn[u] <= 1'b0;
      end else begin
        gocnt[u]  <= 0;
        relcnt[u] <= 0;
      end
    end
  end

  assign unit_done_i   = dn;
  assign unit_result_i = res_m & dn;

  int n_tests;
  int n_fail;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Per-run observations, cycle k = k-th cycle after the start edge
  int           go_cyc [N];
  int           multi_go;
  int           done_cnt;
  int           done_edges;
  int           num_bad;
  logic [N-1:0] go_tr [256];
  logic         d0_tr [256];

  task automatic start_run(input logic [N-1:0] mask, input logic [W-1:0] num);
    @(negedge clk);
    number_i      = num;
    enable_mask_i = mask;
    start_i       = 1'b1;
  endtask

  task automatic run_capture(input int budget, input logic [W-1:0] num_exp);
    for (int u = 0; u < int'(N); u++) go_cyc[u] = 0;
    multi_go   = 0;
    done_cnt   = 0;
    done_edges = -1;
    num_bad    = 0;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      if (k == 1) start_i = 1'b0;
      go_tr[k] = unit_go_o;
      d0_tr[k] = unit_done_i[0];
      for (int u = 0; u < int'(N); u++) if (unit_go_o[u]) go_cyc[u]++;
      if ($countones(unit_go_o) > 1) multi_go++;
      if (unit_number_o !== num_exp) num_bad++;
      if (done_o) begin
        done_cnt++;
        if (done_edges < 0) done_edges = k - 1;
      end
      if ((done_edges >= 0) && (k >= done_edges + 4)) break;
    end
    check("run_completed", 32'(done_edges >= 0), 32'd1);
  endtask

  logic         t6_done [16];
  logic         t6_busy [16];
  logic [W-1:0] t6_num  [16];
  int           cnt;
  int           last0;
  int           first1;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset = 1'b1;
    start_i = 1'b0;
    number_i = '0;
    enable_mask_i = '0;
    never_m = '0;
    res_m = '0;
    for (int u = 0; u < int'(N); u++) begin
      dly[u] = 1;
      rel[u] = 1;
    end

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy",  32'(busy_o), 32'd0);
    check("rst_done",  32'(done_o), 32'd0);
    check("rst_flags", 32'(flags_o), 32'd0);
    check("rst_go",    32'(unit_go_o), 32'd0);
    check("rst_num",   unit_number_o, 32'd0);
    reset = 1'b0;

    // Reset in the middle of WAIT
    never_m = 4'b0001;
    start_run(4'b0001, 32'h1234);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k == 1) start_i = 1'b0;
    end
    check("midrst_go_before", 32'(unit_go_o), 32'h1);
    check("midrst_num_before", unit_number_o, 32'h1234);
    reset = 1'b1;
    #1;
    check("midrst_busy",  32'(busy_o), 32'd0);
    check("midrst_go",    32'(unit_go_o), 32'd0);
    check("midrst_num",   unit_number_o, 32'd0);
    check("midrst_done",  32'(done_o), 32'd0);
    check("midrst_tmo",   32'(timeout_o), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    never_m = '0;
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done_o || busy_o) cnt++;
    end
    check("midrst_stays_idle", 32'(cnt), 32'd0);

    // 89: unit0 fib done after 5 (result 1), unit1 even done after 3 (result 0)
    dly[0] = 5; rel[0] = 1;
    dly[1] = 3; rel[1] = 1;
    res_m = 4'b0001;
    start_run(4'b0011, 32'h59);
    run_capture(100, 32'h59);
    check("fib_go0_cycles", 32'(go_cyc[0]), 32'd6);
    check("fib_go1_cycles", 32'(go_cyc[1]), 32'd4);
    check("fib_go_overlap", 32'(multi_go), 32'd0);
    check("fib_done_pulses", 32'(done_cnt), 32'd1);
    check("fib_latency", 32'(done_edges), 32'd19);
    check("fib_num_stable", 32'(num_bad), 32'd0);
    check("fib_flags", 32'(flags_o), 32'h1);
    check("fib_timeout", 32'(timeout_o), 32'h0);

    // All units masked
    start_run(4'b0000, 32'h7);
    run_capture(50, 32'h7);
    check("mask0_latency", 32'(done_edges), 32'd5);
    check("mask0_go", 32'(go_cyc[0] + go_cyc[1] + go_cyc[2] + go_cyc[3]), 32'd0);
    check("mask0_flags", 32'(flags_o), 32'h0);
    check("mask0_done_pulses", 32'(done_cnt), 32'd1);

    // Unit0 never answers: watchdog after TIMEOUT cycles
    never_m = 4'b0001;
    res_m = 4'b0001;
    start_run(4'b0001, 32'h3);
    run_capture(100, 32'h3);
    check("tmo_go0_cycles", 32'(go_cyc[0]), 32'd8);
    check("tmo_timeout", 32'(timeout_o), 32'h1);
    check("tmo_flags", 32'(flags_o), 32'h0);
    check("tmo_done_pulses", 32'(done_cnt), 32'd1);
    check("tmo_latency", 32'(done_edges), 32'd14);
    never_m = '0;

    // Unit0 keeps done high 2 cycles after go falls: 3 RELEASE cycles
    dly[0] = 2; rel[0] = 2;
    dly[1] = 1; rel[1] = 1;
    res_m = 4'b0011;
    start_run(4'b0011, 32'h8);
    run_capture(100, 32'h8);
    last0 = 0;
    first1 = 0;
    for (int k = 1; k < 100; k++) begin
      if (go_tr[k][0]) last0 = k;
      if (go_tr[k][1] && (first1 == 0)) first1 = k;
    end
    check("rel_go0_cycles", 32'(go_cyc[0]), 32'd3);
    check("rel_gap", 32'(first1 - last0 - 1), 32'd4);
    check("rel_done0_held", 32'(d0_tr[last0 + 2]), 32'd1);
    check("rel_done0_low_at_go1", 32'(d0_tr[first1 - 1]), 32'd0);
    check("rel_flags", 32'(flags_o), 32'h3);

    // start_i held high; number_i changes during runs
    @(negedge clk);
    number_i = 32'hA;
    enable_mask_i = 4'b0000;
    start_i = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (k == 2) number_i = 32'hB;
      if (k == 9) number_i = 32'hC;
      t6_done[k] = done_o;
      t6_busy[k] = busy_o;
      t6_num[k]  = unit_number_o;
    end
    start_i = 1'b0;
    cnt = 0;
    for (int k = 1; k <= 15; k++) if (t6_done[k]) cnt++;
    check("hold_done_pulses", 32'(cnt), 32'd2);
    check("hold_done_run1", 32'(t6_done[6]), 32'd1);
    check("hold_done_run2", 32'(t6_done[13]), 32'd1);
    check("hold_idle1", 32'(t6_busy[7]), 32'd0);
    check("hold_idle2", 32'(t6_busy[14]), 32'd0);
    check("hold_num_run1", t6_num[5], 32'hA);
    check("hold_num_run2", t6_num[8], 32'hB);
    check("hold_num_run3", t6_num[15], 32'hC);
    repeat (10) @(negedge clk);
    check("hold_end_idle", 32'(busy_o), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
